// File: rtl/rr_switch_allocator.sv
// rtl/rr_switch_allocator.sv - per-output round-robin switch allocator for the mesh XY switch
module rr_switch_allocator #(
    parameter int PORT_N = 5,
    parameter int SEL_W  = $clog2(PORT_N)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [PORT_N-1:0]       req_i,
    input  logic [PORT_N*SEL_W-1:0] req_out_sel_i,
    input  logic [PORT_N-1:0]       nxt_fifo_full_i,
    output logic [PORT_N-1:0]       rd_en_o,
    output logic [PORT_N-1:0]       wr_en_o,
    output logic [PORT_N*SEL_W-1:0] xbar_sel_o,
    output logic                    bad_route_o
);

    logic [SEL_W-1:0]  ptr_q   [PORT_N];
    logic [SEL_W-1:0]  ptr_nxt [PORT_N];
    logic [SEL_W-1:0]  winner  [PORT_N];
    logic [PORT_N-1:0] grant_vld;
    logic [PORT_N-1:0] rd_en;
    logic              bad_now;

    // Each output scans inputs from its pointer, wrapping at PORT_N rather than 2^SEL_W.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = '0;
        rd_en     = '0;
        bad_now   = 1'b0;
        for (int o = 0; o < PORT_N; o++) begin
            winner[o]  = '0;
            ptr_nxt[o] = ptr_q[o];
        end
        for (int o = 0; o < PORT_N; o++) begin
            if (!nxt_fifo_full_i[o]) begin
                for (int k = 0; k < PORT_N; k++) begin
                    idx = int'(ptr_q[o]) + k;
                    if (idx >= PORT_N) begin
                        idx = idx - PORT_N;
                    end
                    if (!grant_vld[o] && en_i && req_i[idx] &&
                        int'(req_out_sel_i[idx*SEL_W +: SEL_W]) == o) begin
                        grant_vld[o] = 1'b1;
                        winner[o]    = SEL_W'(idx);
                        rd_en[idx]   = 1'b1;
                        ptr_nxt[o]   = (idx + 1 == PORT_N) ? '0 : SEL_W'(idx + 1);
                    end
                end
            end
        end
        for (int i = 0; i < PORT_N; i++) begin
            if (en_i && req_i[i] && int'(req_out_sel_i[i*SEL_W +: SEL_W]) >= PORT_N) begin
                bad_now = 1'b1;
            end
        end
    end

    assign rd_en_o = rst_i ? '0 : rd_en;

    // Select and write enable are registered to line up with the registered crossbar.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int o = 0; o < PORT_N; o++) begin
                ptr_q[o] <= '0;
            end
            wr_en_o     <= '0;
            xbar_sel_o  <= '0;
            bad_route_o <= 1'b0;
        end else begin
            wr_en_o     <= grant_vld;
            bad_route_o <= bad_now;
            for (int o = 0; o < PORT_N; o++) begin
                if (grant_vld[o]) begin
                    ptr_q[o]                      <= ptr_nxt[o];
                    xbar_sel_o[o*SEL_W +: SEL_W]  <= winner[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_switch_allocator.sv
// tb/tb_rr_switch_allocator.sv - directed scoreboard bench for rr_switch_allocator
module tb_rr_switch_allocator;

    localparam int PORT_N = 5;
    localparam int SEL_W  = 3;

    typedef struct {
        logic [PORT_N-1:0]       wr;
        logic [PORT_N*SEL_W-1:0] xb;
        logic                    bad;
        int                      step;
    } exp_t;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    en_i = 1'b1;
    logic [PORT_N-1:0]       req_i = '0;
    logic [PORT_N*SEL_W-1:0] req_out_sel_i = '0;
    logic [PORT_N-1:0]       nxt_fifo_full_i = '0;
    logic [PORT_N-1:0]       rd_en_o;
    logic [PORT_N-1:0]       wr_en_o;
    logic [PORT_N*SEL_W-1:0] xbar_sel_o;
    logic                    bad_route_o;

    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;
    exp_t sb_q[$];

    rr_switch_allocator #(.PORT_N(PORT_N), .SEL_W(SEL_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .req_i          (req_i),
        .req_out_sel_i  (req_out_sel_i),
        .nxt_fifo_full_i(nxt_fifo_full_i),
        .rd_en_o        (rd_en_o),
        .wr_en_o        (wr_en_o),
        .xbar_sel_o     (xbar_sel_o),
        .bad_route_o    (bad_route_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [PORT_N*SEL_W-1:0] pk(input int s0, s1, s2, s3, s4);
        pk = {SEL_W'(s4), SEL_W'(s3), SEL_W'(s2), SEL_W'(s1), SEL_W'(s0)};
    endfunction

    // Drive one cycle, check the combinational pop, queue the registered result and check it after the edge.
    task automatic step(input logic rst, input logic en, input logic [PORT_N-1:0] req,
                        input logic [PORT_N*SEL_W-1:0] sel, input logic [PORT_N-1:0] full,
                        input logic [PORT_N-1:0] erd, input logic [PORT_N-1:0] ewr,
                        input logic [PORT_N*SEL_W-1:0] exb, input logic ebad);
        exp_t e;
        step_no++;
        rst_i           = rst;
        en_i            = en;
        req_i           = req;
        req_out_sel_i   = sel;
        nxt_fifo_full_i = full;
        #4;
        checks++;
        assert (rd_en_o === erd) else begin
            errors++;
            $error("FAIL rd_en step%0d got %b exp %b", step_no, rd_en_o, erd);
        end
        e.wr   = ewr;
        e.xb   = exb;
        e.bad  = ebad;
        e.step = step_no;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (wr_en_o === e.wr) else begin
            errors++;
            $error("FAIL wr_en step%0d got %b exp %b", e.step, wr_en_o, e.wr);
        end
        checks++;
        assert (xbar_sel_o === e.xb) else begin
            errors++;
            $error("FAIL xbar_sel step%0d got %h exp %h", e.step, xbar_sel_o, e.xb);
        end
        checks++;
        assert (bad_route_o === e.bad) else begin
            errors++;
            $error("FAIL bad_route step%0d got %b exp %b", e.step, bad_route_o, e.bad);
        end
    endtask

    initial begin
        // reset with every input requesting
        step(1, 1, 5'b11111, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 0);
        step(0, 1, 5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 0);
        // parallel disjoint: 0->3, 1->4, 2->0
        step(0, 1, 5'b00111, pk(3,4,0,0,0), 5'b00000, 5'b00111, 5'b11001, pk(2,0,0,0,1), 0);
        // inputs 0,2,4 contend for output 1
        step(0, 1, 5'b10101, pk(1,0,1,0,1), 5'b00000, 5'b00001, 5'b00010, pk(2,0,0,0,1), 0);
        step(0, 1, 5'b10101, pk(1,0,1,0,1), 5'b00000, 5'b00100, 5'b00010, pk(2,2,0,0,1), 0);
        step(0, 1, 5'b10101, pk(1,0,1,0,1), 5'b00000, 5'b10000, 5'b00010, pk(2,4,0,0,1), 0);
        step(0, 1, 5'b10101, pk(1,0,1,0,1), 5'b00000, 5'b00001, 5'b00010, pk(2,0,0,0,1), 0);
        step(0, 1, 5'b10101, pk(1,0,1,0,1), 5'b00000, 5'b00100, 5'b00010, pk(2,2,0,0,1), 0);
        step(0, 1, 5'b10101, pk(1,0,1,0,1), 5'b00000, 5'b10000, 5'b00010, pk(2,4,0,0,1), 0);
        // backpressure on output 2, then release
        step(0, 1, 5'b01000, pk(0,0,0,2,0), 5'b00100, 5'b00000, 5'b00000, pk(2,4,0,0,1), 0);
        step(0, 1, 5'b01000, pk(0,0,0,2,0), 5'b00000, 5'b01000, 5'b00100, pk(2,4,3,0,1), 0);
        // invalid route on input 1
        step(0, 1, 5'b00010, pk(0,7,0,0,0), 5'b00000, 5'b00000, 5'b00000, pk(2,4,3,0,1), 1);
        step(0, 1, 5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, pk(2,4,3,0,1), 0);
        // disabled: no pops, no bad_route, pointers frozen
        step(0, 0, 5'b00011, pk(1,7,0,0,0), 5'b00000, 5'b00000, 5'b00000, pk(2,4,3,0,1), 0);
        step(0, 1, 5'b00101, pk(1,0,1,0,0), 5'b00000, 5'b00001, 5'b00010, pk(2,0,3,0,1), 0);
        // grant, then reset on the following cycle
        step(0, 1, 5'b00100, pk(0,0,1,0,0), 5'b00000, 5'b00100, 5'b00010, pk(2,2,3,0,1), 0);
        step(1, 1, 5'b10100, pk(0,0,1,0,1), 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 0);
        // pointer back at 0 picks input 2 before input 4
        step(0, 1, 5'b10100, pk(0,0,1,0,1), 5'b00000, 5'b00100, 5'b00010, pk(0,2,0,0,0), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_switch_allocator.md
Name: rr_switch_allocator

Overview:
- Per-output round-robin allocator for the mesh XY switch. It replaces the single-winner arbiter/control pair.
- Each cycle it matches input FIFOs (head packet already routed to an output index) to free output ports. Up to PORT_N disjoint input->output transfers are granted in parallel.
- It drives input-FIFO pops combinationally, and crossbar select and downstream write enables one cycle later, aligned with the registered crossbar.

Parameters:
PORT_N, 5, number of switch ports (resource + up to 4 neighbours)
SEL_W, $clog2(PORT_N), width of a port index

Ports:
clk_i  input  1  switch clock
rst_i  input  1  synchronous reset, active-high
en_i  input  1  allocation enable; 0 = no grants, state held
req_i  input  PORT_N  input FIFO i non-empty (~empty)
req_out_sel_i  input  PORT_N*SEL_W  routed output index of head packet of input i, slice i = [SEL_W*(i+1)-1 : SEL_W*i]
nxt_fifo_full_i  input  PORT_N  downstream FIFO of output o full
rd_en_o  output  PORT_N  pop input FIFO i (combinational, grant cycle)
wr_en_o  output  PORT_N  write downstream of output o (registered, grant cycle +1)
xbar_sel_o  output  PORT_N*SEL_W  per-output crossbar input index (registered), slice o
bad_route_o  output  1  registered pulse: a requesting input carried out_sel >= PORT_N

Behaviour:
- Reset (rst_i=1 at posedge): ptr_q[o]=0 for all o; wr_en_o=0; xbar_sel_o=0; bad_route_o=0. rd_en_o is forced to 0 combinationally while rst_i=1. Reset mid-transfer drops any pending write (no wr_en_o the next cycle).
- Candidate: input i is a candidate for output o when req_i[i]=1, req_out_sel_i slice i == o, and en_i=1. An input targets exactly one output, so grants are naturally disjoint per input. i==o (U-turn) is legal.
- Arbitration per output o: if nxt_fifo_full_i[o]=0 and at least one candidate exists, the winner is the first candidate scanning ptr_q[o], ptr_q[o]+1, ... with wrap modulo PORT_N (not 2^SEL_W).
- Full output: no grant, ptr_q[o] unchanged. Inputs targeting it stay blocked (head-of-line) and issue no rd_en.
- Grant cycle N, combinational: rd_en_o[winner]=1. FIFO data is first-word-fall-through and valid in cycle N; the crossbar registers it at the end of N.
- Posedge ending cycle N:
  - ptr_q[o] <= (winner+1)==PORT_N ? 0 : winner+1
  - wr_en_o[o] <= 1
  - xbar_sel_o[o] <= winner
- Output o with no grant in N: wr_en_o[o] <= 0; xbar_sel_o[o] holds its previous value.
- Latency: request visible -> rd_en same cycle -> wr_en_o/xbar_sel_o next cycle. Full throughput of one packet per output per cycle under continuous requests.
- nxt_fifo_full_i is sampled only in the grant cycle. Downstream guarantees room for the one write that lands in N+1, i.e. full asserts with one slot of margin.
- Invalid route: out_sel >= PORT_N. The input is never granted, and bad_route_o <= 1 for the following cycle while it persists. Recovery is by the producer or by reset.
- en_i=0: all rd_en_o=0; next-cycle wr_en_o=0; ptr_q, xbar_sel_o held; bad_route_o <= 0.
- Fairness: a continuously requesting input on a non-full output is granted within PORT_N grants of that output.
- No latches. All sequential logic is in one clk_i domain.

Test Plan:
- Reset: hold rst_i=1 with req_i=5'b11111 -> rd_en_o=0 during reset; first cycle after, wr_en_o=0 and xbar_sel_o=0.
- Parallel disjoint: inputs 0,1,2 route to outputs 3,4,0, all free -> rd_en_o=5'b00111 same cycle. Next cycle: wr_en_o=5'b11001, xbar_sel_o slices o3=0, o4=1, o0=2.
- Round-robin contention: inputs 0,2,4 all route to output 1 continuously (ptr 0) -> grants 0,2,4,0,2,4 on consecutive cycles; ptr_q[1] sequence 1,3,0(wrap),1.
- Backpressure: nxt_fifo_full_i[2]=1 while input 3 routes to 2 -> rd_en_o[3]=0, wr_en_o[2]=0, ptr_q[2] unchanged. Deassert full -> input 3 granted that cycle, wr_en_o[2]=1 the next.
- Bad route / enable: input 1 out_sel=7 (PORT_N=5) -> never popped, bad_route_o=1 one cycle later. en_i=0 with valid requests -> zero rd_en, pointers frozen.
- Reset mid-operation: grant in cycle N, rst_i=1 in N+1 -> wr_en_o=0 after reset; ptr_q back to 0 (verified by the next contention order starting at input 0).
